// File: rtl/wb_arb_pkg.sv
// Shared Wishbone widths, cycle-type constants and index-width helper for the bus arbiter.
package wb_arb_pkg;

  localparam int cti_w = 3;
  localparam int bte_w = 2;

  localparam logic [cti_w-1:0] cti_classic = 3'b000;
  localparam logic [cti_w-1:0] cti_eob     = 3'b111;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_arb_core.sv
// Grant engine: holds the owner while its CYC is high, otherwise grants the next requester 1 cycle later.
// Rotating search by default; `WB_ARB_FIXED_PRIO_EN` makes index 0 highest priority and drops the last register.
module wb_rr_arb_core
  import wb_arb_pkg::*;
#(
  parameter int num_masters = 5,
  localparam int iw = idx_w(num_masters)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [num_masters-1:0] req,
  output logic [num_masters-1:0] gnt,
  output logic [iw-1:0]          last
);

  logic                   owner_active;
  logic [num_masters-1:0] nxt_gnt;
`ifndef WB_ARB_FIXED_PRIO_EN
  logic [iw-1:0]          nxt_idx;
`endif

  assign owner_active = |(gnt & req);

  always_comb begin
    int            start;
    logic [iw-1:0] cand;
    logic          found;
    nxt_gnt = '0;
    found   = 1'b0;
    cand    = '0;
`ifdef WB_ARB_FIXED_PRIO_EN
    start   = 0;
`else
    nxt_idx = last;
    start   = int'(last) + 1;
`endif
    for (int k = 0; k < num_masters; k++) begin
      cand = iw'((start + k) % num_masters);
      if (!found && req[cand]) begin
        found         = 1'b1;
        nxt_gnt[cand] = 1'b1;
`ifndef WB_ARB_FIXED_PRIO_EN
        nxt_idx       = cand;
`endif
      end
    end
  end

`ifdef WB_ARB_FIXED_PRIO_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt <= '0;
    end else if (!owner_active) begin
      gnt <= nxt_gnt;
    end
  end

  // Without a pointer register, last is just the encoded current grant.
  always_comb begin
    last = '0;
    for (int i = 0; i < num_masters; i++) begin
      if (gnt[i]) last = iw'(i);
    end
  end
`else
  // Pointer starts at the top index so the first search begins at master 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt  <= '0;
      last <= iw'(num_masters - 1);
    end else if (!owner_active) begin
      gnt  <= nxt_gnt;
      last <= nxt_idx;
    end
  end
`endif

endmodule

// File: rtl/wb_rr_arbiter.sv
// N-to-1 Wishbone B3 arbiter: one owner per CYC period, grant latency 1, no preemption.
// Request/response muxing only; `WB_ARB_FIXED_PRIO_EN` selects fixed priority in the core.
module wb_rr_arbiter
  import wb_arb_pkg::*;
#(
  parameter int num_masters = 5,
  parameter int aw = 32,
  parameter int dw = 32
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_ni,
  input  logic [num_masters*aw-1:0]     wbm_adr_i,
  input  logic [num_masters*dw-1:0]     wbm_dat_i,
  input  logic [num_masters*dw/8-1:0]   wbm_sel_i,
  input  logic [num_masters-1:0]        wbm_we_i,
  input  logic [num_masters-1:0]        wbm_cyc_i,
  input  logic [num_masters-1:0]        wbm_stb_i,
  input  logic [num_masters*cti_w-1:0]  wbm_cti_i,
  input  logic [num_masters*bte_w-1:0]  wbm_bte_i,
  output logic [num_masters*dw-1:0]     wbm_dat_o,
  output logic [num_masters-1:0]        wbm_ack_o,
  output logic [num_masters-1:0]        wbm_err_o,
  output logic [num_masters-1:0]        wbm_rty_o,
  output logic [aw-1:0]                 wbs_adr_o,
  output logic [dw-1:0]                 wbs_dat_o,
  output logic [dw/8-1:0]               wbs_sel_o,
  output logic                          wbs_we_o,
  output logic                          wbs_cyc_o,
  output logic                          wbs_stb_o,
  output logic [cti_w-1:0]              wbs_cti_o,
  output logic [bte_w-1:0]              wbs_bte_o,
  input  logic [dw-1:0]                 wbs_dat_i,
  input  logic                          wbs_ack_i,
  input  logic                          wbs_err_i,
  input  logic                          wbs_rty_i
);

  localparam int iw = idx_w(num_masters);
  localparam int sw = dw / 8;

  logic [num_masters-1:0] gnt;
  logic [iw-1:0]          last;
  logic                   granted;

  wb_rr_arb_core #(
    .num_masters(num_masters)
  ) u_core (
    .clk  (wb_clk_i),
    .rst_n(wb_rst_ni),
    .req  (wbm_cyc_i),
    .gnt  (gnt),
    .last (last)
  );

  assign granted = |gnt;

  // last always names the master whose gnt bit is set, so it doubles as the mux select.
  always_comb begin
    wbs_adr_o = '0;
    wbs_dat_o = '0;
    wbs_sel_o = '0;
    wbs_we_o  = 1'b0;
    wbs_cyc_o = 1'b0;
    wbs_stb_o = 1'b0;
    wbs_cti_o = '0;
    wbs_bte_o = '0;
    if (granted) begin
      wbs_adr_o = wbm_adr_i[last*aw +: aw];
      wbs_dat_o = wbm_dat_i[last*dw +: dw];
      wbs_sel_o = wbm_sel_i[last*sw +: sw];
      wbs_we_o  = wbm_we_i[last];
      wbs_cyc_o = wbm_cyc_i[last];
      wbs_stb_o = wbm_stb_i[last];
      wbs_cti_o = wbm_cti_i[last*cti_w +: cti_w];
      wbs_bte_o = wbm_bte_i[last*bte_w +: bte_w];
    end
  end

  assign wbm_ack_o = gnt & {num_masters{wbs_ack_i}};
  assign wbm_err_o = gnt & {num_masters{wbs_err_i}};
  assign wbm_rty_o = gnt & {num_masters{wbs_rty_i}};
  assign wbm_dat_o = {num_masters{wbs_dat_i}};

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Bench for wb_rr_arbiter: vector table for first-grant selection, scoreboarded transactions
// against a registered-ack memory slave, and hand sequences for handover, burst, error and reset.
module tb_wb_rr_arbiter;

  localparam int N  = 5;
  localparam int AW = 32;
  localparam int DW = 32;

  logic wb_clk_i = 1'b0;
  logic wb_rst_ni;

  logic [N*AW-1:0]   wbm_adr_i;
  logic [N*DW-1:0]   wbm_dat_i;
  logic [N*DW/8-1:0] wbm_sel_i;
  logic [N-1:0]      wbm_we_i, wbm_cyc_i, wbm_stb_i;
  logic [N*3-1:0]    wbm_cti_i;
  logic [N*2-1:0]    wbm_bte_i;
  logic [N*DW-1:0]   wbm_dat_o;
  logic [N-1:0]      wbm_ack_o, wbm_err_o, wbm_rty_o;
  logic [AW-1:0]     wbs_adr_o;
  logic [DW-1:0]     wbs_dat_o;
  logic [DW/8-1:0]   wbs_sel_o;
  logic              wbs_we_o, wbs_cyc_o, wbs_stb_o;
  logic [2:0]        wbs_cti_o;
  logic [1:0]        wbs_bte_o;
  logic [DW-1:0]     wbs_dat_i;
  logic              wbs_ack_i, wbs_err_i, wbs_rty_i;

  logic [N-1:0] m_cyc, m_stb, m_we;
  logic [31:0]  m_adr [N];
  logic [31:0]  m_dat [N];
  logic [3:0]   m_sel [N];
  logic [2:0]   m_cti [N];

  logic        s_ack_r, s_ack_man, s_err_man, s_rty_man, s_hold;
  logic [31:0] s_rdata, s_dat_xor;
  logic [31:0] mem [256];

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  int          exp_own [$];
  logic [31:0] exp_dat [$];

  // single-master instance
  logic        c1_cyc, c1_stb, one1;
  logic [31:0] n1_dat_o, n1_adr_o, n1_dat_so;
  logic [0:0]  n1_ack_o, n1_err_o, n1_rty_o;
  logic [3:0]  n1_sel_o;
  logic        n1_we_o, n1_cyc_o, n1_stb_o;
  logic [2:0]  n1_cti_o;
  logic [1:0]  n1_bte_o;

  always #5 wb_clk_i = ~wb_clk_i;

  assign wbm_cyc_i = m_cyc;
  assign wbm_stb_i = m_stb;
  assign wbm_we_i  = m_we;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      wbm_adr_i[i*AW +: AW] = m_adr[i];
      wbm_dat_i[i*DW +: DW] = m_dat[i];
      wbm_sel_i[i*4 +: 4]   = m_sel[i];
      wbm_cti_i[i*3 +: 3]   = m_cti[i];
      wbm_bte_i[i*2 +: 2]   = 2'b00;
    end
  end

  assign wbs_ack_i = s_ack_r | s_ack_man;
  assign wbs_err_i = s_err_man;
  assign wbs_rty_i = s_rty_man;
  assign wbs_dat_i = s_rdata ^ s_dat_xor;

  // Registered-feedback memory slave: one ack per strobe, the cycle after it is seen.
  always @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      s_ack_r <= 1'b0;
      s_rdata <= '0;
    end else if (wbs_cyc_o && wbs_stb_o && !s_ack_r && !s_hold) begin
      s_ack_r <= 1'b1;
      if (wbs_we_o) begin
        for (int b = 0; b < 4; b++)
          if (wbs_sel_o[b]) mem[wbs_adr_o[9:2]][8*b +: 8] <= wbs_dat_o[8*b +: 8];
      end else begin
        s_rdata <= mem[wbs_adr_o[9:2]];
      end
    end else begin
      s_ack_r <= 1'b0;
    end
  end

  wb_rr_arbiter #(.num_masters(N), .aw(AW), .dw(DW)) dut (
    .wb_clk_i (wb_clk_i),  .wb_rst_ni(wb_rst_ni),
    .wbm_adr_i(wbm_adr_i), .wbm_dat_i(wbm_dat_i), .wbm_sel_i(wbm_sel_i),
    .wbm_we_i (wbm_we_i),  .wbm_cyc_i(wbm_cyc_i), .wbm_stb_i(wbm_stb_i),
    .wbm_cti_i(wbm_cti_i), .wbm_bte_i(wbm_bte_i),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbm_rty_o(wbm_rty_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o),
    .wbs_we_o (wbs_we_o),  .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o),
    .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .wbs_rty_i(wbs_rty_i)
  );

  wb_rr_arbiter #(.num_masters(1), .aw(32), .dw(32)) dut1 (
    .wb_clk_i (wb_clk_i),  .wb_rst_ni(wb_rst_ni),
    .wbm_adr_i(32'h55),    .wbm_dat_i(32'h0),     .wbm_sel_i(4'hF),
    .wbm_we_i (1'b0),      .wbm_cyc_i(c1_cyc),    .wbm_stb_i(c1_stb),
    .wbm_cti_i(3'b000),    .wbm_bte_i(2'b00),
    .wbm_dat_o(n1_dat_o),  .wbm_ack_o(n1_ack_o),  .wbm_err_o(n1_err_o),
    .wbm_rty_o(n1_rty_o),
    .wbs_adr_o(n1_adr_o),  .wbs_dat_o(n1_dat_so), .wbs_sel_o(n1_sel_o),
    .wbs_we_o (n1_we_o),   .wbs_cyc_o(n1_cyc_o),  .wbs_stb_o(n1_stb_o),
    .wbs_cti_o(n1_cti_o),  .wbs_bte_o(n1_bte_o),
    .wbs_dat_i(32'h0),     .wbs_ack_i(one1),      .wbs_err_i(1'b0),
    .wbs_rty_i(1'b0)
  );

  task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Ownership scoreboard: each slave-side ack must reach exactly the next expected master.
  initial begin
    forever begin
      @(negedge wb_clk_i);
      if (mon_en && wbm_ack_o != '0) begin
        if (exp_own.size() == 0) begin
          check_eq("unexpected_ack", {59'd0, wbm_ack_o}, 64'd0);
        end else begin
          logic [N-1:0] ev;
          int e;
          e = exp_own.pop_front();
          ev = '0;
          ev[e] = 1'b1;
          check_eq("ack_owner", {59'd0, wbm_ack_o}, {59'd0, ev});
        end
      end
    end
  end

  task automatic do_reset();
    wb_rst_ni = 1'b0;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
  endtask

  task automatic xfer(input int m, input logic we_v, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] c, input bit keep, output logic [31:0] rd);
    bit got;
    got = 1'b0;
    rd  = '0;
    @(negedge wb_clk_i);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we_v;
    m_adr[m] = a; m_dat[m] = d; m_sel[m] = 4'hF; m_cti[m] = c;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge wb_clk_i);
      if (wbm_ack_o[m]) begin
        got = 1'b1;
        rd  = wbm_dat_o[m*DW +: DW];
      end
    end
    m_stb[m] = 1'b0;
    if (!keep) m_cyc[m] = 1'b0;
    if (!got) check_eq("xfer_timeout", 64'd0, 64'd1);
  endtask

  task automatic master_loop(input int m);
    logic [31:0] rd;
    repeat (2) xfer(m, 1'b0, 32'(m) << 8, 32'h0, 3'b000, 1'b0, rd);
  endtask

  typedef struct {
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [31:0]  adr;
  } vec_t;
  vec_t vecs [7];

  initial begin
    logic [31:0] rd, rd0;
    vecs[0] = '{req: 5'b00000, gnt: 5'b00000, adr: 32'h0};
    vecs[1] = '{req: 5'b00001, gnt: 5'b00001, adr: 32'h1000};
    vecs[2] = '{req: 5'b00100, gnt: 5'b00100, adr: 32'h1020};
    vecs[3] = '{req: 5'b10100, gnt: 5'b00100, adr: 32'h1020};
    vecs[4] = '{req: 5'b10000, gnt: 5'b10000, adr: 32'h1040};
    vecs[5] = '{req: 5'b11110, gnt: 5'b00010, adr: 32'h1010};
    vecs[6] = '{req: 5'b11111, gnt: 5'b00001, adr: 32'h1000};

    m_cyc = '0; m_stb = '0; m_we = '0;
    for (int i = 0; i < N; i++) begin
      m_adr[i] = '0; m_dat[i] = '0; m_sel[i] = '0; m_cti[i] = '0;
    end
    s_ack_man = 1'b1; s_err_man = 1'b0; s_rty_man = 1'b0; s_hold = 1'b1; s_dat_xor = '0;
    c1_cyc = 1'b0; c1_stb = 1'b0; one1 = 1'b1;
    wb_rst_ni = 1'b0;
    repeat (2) @(negedge wb_clk_i);

    // Reset state: outputs idle and a stray slave ack is dropped.
    check_eq("rst_cyc", {63'd0, wbs_cyc_o}, 64'd0);
    check_eq("rst_adr", {32'd0, wbs_adr_o}, 64'd0);
    check_eq("rst_ack_gated", {59'd0, wbm_ack_o}, 64'd0);
    wb_rst_ni = 1'b1;

    // First grant out of reset, with the slave ack forced so wbm_ack_o mirrors gnt.
    for (int v = 0; v < 7; v++) begin
      do_reset();
      for (int i = 0; i < N; i++) m_adr[i] = 32'h1000 + 32'(i) * 32'h10;
      m_cyc = vecs[v].req;
      m_stb = vecs[v].req;
      #1;
      check_eq($sformatf("vec%0d_latency", v), {59'd0, wbm_ack_o}, 64'd0);
      @(negedge wb_clk_i);
      check_eq($sformatf("vec%0d_gnt", v), {59'd0, wbm_ack_o}, {59'd0, vecs[v].gnt});
      check_eq($sformatf("vec%0d_adr", v), {32'd0, wbs_adr_o}, {32'd0, vecs[v].adr});
      m_cyc = '0;
      m_stb = '0;
    end
    s_ack_man = 1'b0;
    s_hold    = 1'b0;
    @(negedge wb_clk_i);

    // Single master: grant trails CYC by one cycle.
    c1_cyc = 1'b1; c1_stb = 1'b1;
    #1 check_eq("n1_latency", {63'd0, n1_ack_o}, 64'd0);
    @(negedge wb_clk_i);
    check_eq("n1_gnt", {63'd0, n1_ack_o}, 64'd1);
    check_eq("n1_cyc", {63'd0, n1_cyc_o}, 64'd1);
    c1_cyc = 1'b0; c1_stb = 1'b0;
    #1 check_eq("n1_cyc_drop", {63'd0, n1_cyc_o}, 64'd0);
    @(negedge wb_clk_i);
    check_eq("n1_gnt_drop", {63'd0, n1_ack_o}, 64'd0);

    // Masters 0 and 2 together: 0 first, 2 on the edge that sees 0 drop CYC.
    mon_en = 1'b1;
    do_reset();
    exp_own.push_back(0);
    exp_own.push_back(2);
    m_adr[0] = 32'h2000; m_adr[2] = 32'h2200; m_we = '0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    #1 check_eq("t1_idle", {63'd0, wbs_cyc_o}, 64'd0);
    @(negedge wb_clk_i);
    check_eq("t1_grant0", {32'd0, wbs_adr_o}, 64'h2000);
    check_eq("t1_no_ack2", {63'd0, wbm_ack_o[2]}, 64'd0);
    @(negedge wb_clk_i);
    check_eq("t1_ack0", {59'd0, wbm_ack_o}, 64'b00001);
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    @(negedge wb_clk_i);
    check_eq("t1_handover", {32'd0, wbs_adr_o}, 64'h2200);
    check_eq("t1_ack_gap", {59'd0, wbm_ack_o}, 64'd0);
    @(negedge wb_clk_i);
    check_eq("t1_ack2", {59'd0, wbm_ack_o}, 64'b00100);
    m_cyc[2] = 1'b0; m_stb[2] = 1'b0;
    @(negedge wb_clk_i);

    // All five request continuously: strict rotation 0..4, twice.
    do_reset();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) exp_own.push_back(i);
    fork
      master_loop(0);
      master_loop(1);
      master_loop(2);
      master_loop(3);
      master_loop(4);
    join
    repeat (2) @(negedge wb_clk_i);
    check_eq("rr_drain", 64'(exp_own.size()), 64'd0);

    // Write then read back through master 1.
    exp_own.push_back(1);
    xfer(1, 1'b1, 32'h100, 32'hDEADBEEF, 3'b000, 1'b0, rd);
    exp_own.push_back(1);
    exp_dat.push_back(32'hDEADBEEF);
    xfer(1, 1'b0, 32'h100, 32'h0, 3'b000, 1'b0, rd);
    check_eq("m1_readback", {32'd0, rd}, {32'd0, exp_dat.pop_front()});

    // Burst on master 3 keeps the grant while master 0 waits.
    do_reset();
    repeat (4) exp_own.push_back(3);
    exp_own.push_back(0);
    exp_dat.push_back(32'hB000_0003);
    fork
      begin
        for (int b = 0; b < 4; b++)
          xfer(3, 1'b1, 32'h300 + 32'(b) * 4, 32'hB000_0000 + 32'(b),
               (b == 3) ? 3'b111 : 3'b010, (b != 3), rd);
      end
      begin
        repeat (3) @(negedge wb_clk_i);
        xfer(0, 1'b0, 32'h30C, 32'h0, 3'b000, 1'b0, rd0);
      end
    join
    check_eq("burst_readback", {32'd0, rd0}, {32'd0, exp_dat.pop_front()});
    @(negedge wb_clk_i);
    check_eq("burst_drain", 64'(exp_own.size()), 64'd0);

    // Error and retry reach only the owner; read data broadcasts to every slice.
    mon_en = 1'b0;
    s_hold = 1'b1;
    do_reset();
    s_dat_xor = 32'hA5C3_0F1E;
    m_adr[4] = 32'h4444; m_cyc[4] = 1'b1; m_stb[4] = 1'b1;
    @(negedge wb_clk_i);
    m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    @(negedge wb_clk_i);
    s_err_man = 1'b1;
    #1;
    check_eq("err_m4", {59'd0, wbm_err_o}, 64'b10000);
    check_eq("err_no_ack", {59'd0, wbm_ack_o}, 64'd0);
    check_eq("err_adr", {32'd0, wbs_adr_o}, 64'h4444);
    for (int i = 0; i < N; i++)
      check_eq($sformatf("dat_slice%0d", i), {32'd0, wbm_dat_o[i*DW +: DW]}, 64'hA5C3_0F1E);
    s_err_man = 1'b0; s_rty_man = 1'b1;
    #1;
    check_eq("rty_m4", {59'd0, wbm_rty_o}, 64'b10000);
    check_eq("rty_no_err", {59'd0, wbm_err_o}, 64'd0);
    s_rty_man = 1'b0;
    m_cyc[4] = 1'b0; m_stb[4] = 1'b0;
    @(negedge wb_clk_i);
    s_err_man = 1'b1;
    #1 check_eq("err_m1", {59'd0, wbm_err_o}, 64'b00010);
    s_err_man = 1'b0;
    m_cyc = '0; m_stb = '0; s_dat_xor = '0;
    @(negedge wb_clk_i);

    // Reset mid-transfer aborts asynchronously; master 0 then beats master 4.
    do_reset();
    m_adr[0] = 32'h1000; m_adr[2] = 32'h1020; m_adr[4] = 32'h1040;
    m_cyc[2] = 1'b1; m_stb[2] = 1'b1;
    @(negedge wb_clk_i);
    check_eq("t6_granted", {63'd0, wbs_cyc_o}, 64'd1);
    #2 wb_rst_ni = 1'b0;
    #1 check_eq("t6_async_abort", {63'd0, wbs_cyc_o}, 64'd0);
    m_cyc = '0; m_stb = '0;
    m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_cyc[4] = 1'b1; m_stb[4] = 1'b1;
    @(negedge wb_clk_i);
    wb_rst_ni = 1'b1;
    @(negedge wb_clk_i);
    check_eq("t6_m0_wins", {32'd0, wbs_adr_o}, 64'h1000);
    check_eq("t6_cyc", {63'd0, wbs_cyc_o}, 64'd1);
    m_cyc = '0; m_stb = '0;
    @(negedge wb_clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
